// File: rtl/neosd_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// neosd_pkg - shared constants and types for the neosd clock-enable generator
// Revision: 1.0
// ----------------------------------------------------------------------------
package neosd_pkg;

  localparam int unsigned CLKGEN_CNT_W = 12;
  localparam int unsigned CLKGEN_DIV_W = 16;

  // Tap k uses bits [4k+3:4k]; tap 0 is the fastest (counter bit 0).
  localparam logic [31:0] CLKGEN_TAP_SEL = {4'd11, 4'd10, 4'd9, 4'd6, 4'd5, 4'd2, 4'd1, 4'd0};

  typedef logic [3:0] tap_idx_t;

endpackage
`default_nettype wire

// File: rtl/neosd_clkgen_div.sv
`default_nettype none
// ----------------------------------------------------------------------------
// neosd_clkgen_div - runtime divide-by-(N+1) tick and square-wave channel
// Revision: 1.0
// ----------------------------------------------------------------------------
module neosd_clkgen_div #(
  parameter int unsigned      DIV_W   = 16,
  parameter logic [DIV_W-1:0] DIV_RST = '0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             div_ld_i,
  output logic             div_pend_o,
  output logic             div_tick_o,
  output logic             div_clk_o
);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] shadow;
  logic             wrap;
  logic [DIV_W-1:0] reload;

  assign wrap = (div_cnt == '0);

  // A load arriving on the wrap edge bypasses the shadow register.
  assign reload = div_ld_i   ? div_i  :
                  div_pend_o ? shadow : div_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_q      <= DIV_RST;
      div_cnt    <= DIV_RST;
      shadow     <= '0;
      div_pend_o <= 1'b0;
      div_tick_o <= 1'b0;
      div_clk_o  <= 1'b0;
    end else begin
      div_tick_o <= 1'b0;
      if (clr_i) begin
        div_cnt   <= div_q;
        div_clk_o <= 1'b0;
        if (div_ld_i) begin
          shadow     <= div_i;
          div_pend_o <= 1'b1;
        end
      end else if (en_i && wrap) begin
        div_tick_o <= 1'b1;
        div_clk_o  <= ~div_clk_o;
        div_q      <= reload;
        div_cnt    <= reload;
        div_pend_o <= 1'b0;
        if (div_ld_i) begin
          shadow <= div_i;
        end
      end else begin
        if (en_i) begin
          div_cnt <= div_cnt - DIV_W'(1);
        end
        if (div_ld_i) begin
          shadow     <= div_i;
          div_pend_o <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/neosd_clkgen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// neosd_clkgen - shared prescaler with power-of-two enable taps plus divider
// Revision: 1.0
// ----------------------------------------------------------------------------
module neosd_clkgen
  import neosd_pkg::*;
#(
  parameter int unsigned               CNT_W    = CLKGEN_CNT_W,
  parameter int unsigned               NUM_TAPS = 8,
  parameter logic [4*NUM_TAPS-1:0]     TAP_SEL  = CLKGEN_TAP_SEL,
  parameter int unsigned               DIV_W    = CLKGEN_DIV_W,
  parameter logic [DIV_W-1:0]          DIV_RST  = '0
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                en_i,
  input  logic                clr_i,
  output logic [NUM_TAPS-1:0] clkgen_o,
  input  logic [DIV_W-1:0]    div_i,
  input  logic                div_ld_i,
  output logic                div_pend_o,
  output logic                div_tick_o,
  output logic                div_clk_o
);

  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_nxt;
  logic [NUM_TAPS-1:0] rise;

  assign cnt_nxt = cnt + CNT_W'(1);

  // A tap fires only on a 0->1 edge of its bit, so the all-ones wrap is silent.
  for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
    localparam tap_idx_t IDX = TAP_SEL[4*k +: 4];
    assign rise[k] = ~cnt[IDX] & cnt_nxt[IDX];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt      <= '0;
      clkgen_o <= '0;
    end else if (clr_i) begin
      cnt      <= '0;
      clkgen_o <= '0;
    end else if (en_i) begin
      cnt      <= cnt_nxt;
      clkgen_o <= rise;
    end else begin
      clkgen_o <= '0;
    end
  end

  neosd_clkgen_div #(
    .DIV_W   (DIV_W),
    .DIV_RST (DIV_RST)
  ) u_div (
    .clk        (clk),
    .rstn       (rstn),
    .en_i       (en_i),
    .clr_i      (clr_i),
    .div_i      (div_i),
    .div_ld_i   (div_ld_i),
    .div_pend_o (div_pend_o),
    .div_tick_o (div_tick_o),
    .div_clk_o  (div_clk_o)
  );

endmodule
`default_nettype wire

// File: tb/tb_neosd_clkgen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_neosd_clkgen - scoreboard bench for the neosd clock-enable generator
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_neosd_clkgen;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        en_i = 1'b0;
  logic        clr_i = 1'b0;
  logic [7:0]  clkgen_o;
  logic [15:0] div_i = '0;
  logic        div_ld_i = 1'b0;
  logic        div_pend_o;
  logic        div_tick_o;
  logic        div_clk_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [10:0] exp_q[$];

  // Reference state, described from the outside: counter value and divider phase.
  int          m_cnt = 0;
  logic [7:0]  m_taps = '0;
  int          m_divq = 0, m_divcnt = 0, m_shadow = 0;
  logic        m_pend = 1'b0, m_tick = 1'b0, m_dclk = 1'b0;
  int          tsel[8] = '{0, 1, 2, 5, 6, 9, 10, 11};

  always #5 clk = ~clk;

  neosd_clkgen dut (
    .clk        (clk),
    .rstn       (rstn),
    .en_i       (en_i),
    .clr_i      (clr_i),
    .clkgen_o   (clkgen_o),
    .div_i      (div_i),
    .div_ld_i   (div_ld_i),
    .div_pend_o (div_pend_o),
    .div_tick_o (div_tick_o),
    .div_clk_o  (div_clk_o)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model(input logic en, input logic clr, input logic ld, input int dv);
    if (!rstn) begin
      m_cnt = 0; m_taps = '0; m_divq = 0; m_divcnt = 0; m_shadow = 0;
      m_pend = 0; m_tick = 0; m_dclk = 0;
    end else if (clr) begin
      m_cnt = 0; m_taps = '0; m_tick = 0; m_dclk = 0; m_divcnt = m_divq;
      if (ld) begin m_shadow = dv; m_pend = 1; end
    end else if (en) begin
      m_cnt = (m_cnt + 1) % 4096;
      for (int k = 0; k < 8; k++)
        m_taps[k] = ((m_cnt % (2 ** (tsel[k] + 1))) == (2 ** tsel[k]));
      if (m_divcnt == 0) begin
        m_tick = 1; m_dclk = ~m_dclk;
        if (ld) m_divq = dv;
        else if (m_pend) m_divq = m_shadow;
        m_pend = 0; m_divcnt = m_divq;
      end else begin
        m_tick = 0; m_divcnt = m_divcnt - 1;
        if (ld) begin m_shadow = dv; m_pend = 1; end
      end
    end else begin
      m_taps = '0; m_tick = 0;
      if (ld) begin m_shadow = dv; m_pend = 1; end
    end
  endtask

  // One clock: drive at negedge, queue expectation, return just after posedge.
  task automatic step(input logic en, input logic clr, input logic ld, input int dv);
    @(negedge clk);
    en_i = en; clr_i = clr; div_ld_i = ld; div_i = 16'(dv);
    model(en, clr, ld, dv);
    exp_q.push_back({m_taps, m_tick, m_dclk, m_pend});
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [10:0] e;
      logic [10:0] a;
      e = exp_q.pop_front();
      a = {clkgen_o, div_tick_o, div_clk_o, div_pend_o};
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL outputs {taps,tick,dclk,pend}: got %b expected %b (t=%0t)", a, e, $time);
      end
    end
  end

  initial begin
    int c_tap0, c_tap7, at_tap7, c_tick, pend_seen, width_bad, gap, t0a, t0b;
    logic [7:0] prev;
    logic found;

    // Reset state
    step(0, 0, 0, 0);
    check("reset_outputs", int'({clkgen_o, div_tick_o, div_clk_o, div_pend_o}), 0);
    step(0, 0, 0, 0);
    rstn = 1'b1;

    // Full prescaler cycle; first cycle also loads div=4 (applied at once).
    c_tap0 = 0; c_tap7 = 0; at_tap7 = -1; c_tick = 0; pend_seen = 0; width_bad = 0;
    prev = '0;
    for (int i = 1; i <= 4096; i++) begin
      step(1, 0, (i == 1), 4);
      if (clkgen_o[0]) c_tap0++;
      if (clkgen_o[7]) begin c_tap7++; at_tap7 = i; end
      if (div_tick_o) c_tick++;
      if (div_pend_o) pend_seen++;
      if ((prev & clkgen_o) != 0) width_bad++;
      prev = clkgen_o;
    end
    check("tap0_pulses", c_tap0, 2048);
    check("tap7_pulses", c_tap7, 1);
    check("tap7_cycle", at_tap7, 2048);
    check("pulse_width_viol", width_bad, 0);
    check("div4_tick_count", c_tick, 820);
    check("div4_pend_seen", pend_seen, 0);

    // Pause at cnt=5 then resume; tap0 must return at cnt=7.
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0);
    step(1, 0, 0, 0); t0a = int'(clkgen_o[0]);
    step(1, 0, 0, 0); t0b = int'(clkgen_o[0]);
    check("resume_tap0_cnt6", t0a, 0);
    check("resume_tap0_cnt7", t0b, 1);

    // Restart at cnt=100 with en high; tap2 first pulse 4 enabled cycles later.
    for (int i = 0; i < 93; i++) step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    check("clr_dclk", int'(div_clk_o), 0);
    check("clr_taps", int'(clkgen_o), 0);
    for (int i = 1; i <= 4; i++) begin
      step(1, 0, 0, 0);
      check($sformatf("clr_tap2_step%0d", i), int'(clkgen_o[2]), (i == 4) ? 1 : 0);
    end

    // Run at div=9, then overwrite a pending load; only 3 may take effect.
    step(1, 0, 1, 9);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step(1, 0, 0, 0);
      if (div_tick_o && !div_pend_o) found = 1;
    end
    check("div9_applied", int'(found), 1);
    step(1, 0, 1, 2);
    check("pend_after_ld2", int'(div_pend_o), 1);
    step(1, 0, 1, 3);
    check("pend_after_ld3", int'(div_pend_o), 1);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1, 0, 0, 0);
      if (div_tick_o) found = 1;
      else if (!div_pend_o) break;
    end
    check("wrap_applies_load", int'(found), 1);
    check("pend_cleared_at_wrap", int'(div_pend_o), 0);
    for (int n = 0; n < 2; n++) begin
      gap = 0;
      for (int i = 0; i < 20; i++) begin
        step(1, 0, 0, 0);
        gap++;
        if (div_tick_o) break;
      end
      check($sformatf("div3_period_%0d", n), gap, 4);
    end

    // Async reset mid-period with div_clk high and a load pending.
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1, 0, 0, 0);
      if (div_tick_o && div_clk_o) found = 1;
    end
    check("reach_dclk_high", int'(found), 1);
    step(1, 0, 1, 7);
    check("pre_rst_pend", int'(div_pend_o), 1);
    #2;
    rstn = 1'b0;
    #1;
    check("async_rst_outputs", int'({clkgen_o, div_tick_o, div_clk_o, div_pend_o}), 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    rstn = 1'b1;
    c_tick = 0;
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 0, 0);
      if (div_tick_o) c_tick++;
    end
    check("div_rst_restored_ticks", c_tick, 6);

    @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
